// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: next-PC redirect, instruction-memory handshake and decode-side buffer.
// The master modport is the fetch unit; the slave modport is its surroundings (memory, decode, next-PC).
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc4;
  logic        adel;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc4, adel
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc4, adel
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry instruction buffer.
// Redirects override every transition; in-flight responses for stale addresses are dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        adel_q, adel_d;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      adel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      adel_q    <= adel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    adel_d    = bus.redirect && is_misaligned(bus.redirect_pc);

    if (bus.redirect) begin
      fpc_d = word_align(bus.redirect_pc);
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.imem_gnt) begin
          // A grant alongside a redirect leaves a response in flight for the old address.
          state_d = bus.redirect ? DROP : WAIT;
        end
      end

      WAIT: begin
        if (bus.redirect) begin
          state_d = bus.imem_rvalid ? FETCH : DROP;
        end else if (bus.imem_rvalid) begin
          inst_d    = bus.imem_rdata;
          inst_pc_d = fpc_q;
          fpc_d     = fpc_q + 32'd4;
          state_d   = HOLD;
        end
      end

      DROP: begin
        if (bus.imem_rvalid) begin
          state_d = FETCH;
        end
      end

      HOLD: begin
        // Redirect squashes the buffered word even when decode is accepting it.
        if (bus.redirect || bus.inst_ready) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.imem_addr  = fpc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc4        = inst_pc_q + 32'd4;
  assign bus.adel       = adel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, stalls, redirects, wrap and mid-run reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0b want 0", bus.imem_req); end
    vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", bus.inst_valid); end
    vectors++; if (bus.imem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL rst_addr got %h want 00003000", bus.imem_addr); end
    vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst got %h want 00000000", bus.inst); end
    vectors++; if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc got %h want 00000000", bus.inst_pc); end
    vectors++; if (bus.pc4 !== 32'h4) begin miscompares++; $display("FAIL rst_pc4 got %h want 00000004", bus.pc4); end
    vectors++; if (bus.adel !== 1'b0) begin miscompares++; $display("FAIL rst_adel got %0b want 0", bus.adel); end
  endtask

  task automatic test_basic_fetch();
    rst_n = 1'b1;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req got %0b want 0", bus.imem_req); end
    step();
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %0b want 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL first_addr got %h want 00003000", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin miscompares++; $display("FAIL wait_req_valid got %b want 00", {bus.imem_req, bus.inst_valid}); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2408_0001;
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.inst_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %0b want 1", bus.inst_valid); end
    vectors++; if (bus.inst !== 32'h2408_0001) begin miscompares++; $display("FAIL basic_inst got %h want 24080001", bus.inst); end
    vectors++; if (bus.inst_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL basic_inst_pc got %h want 00003000", bus.inst_pc); end
    vectors++; if (bus.pc4 !== 32'h0000_3004) begin miscompares++; $display("FAIL basic_pc4 got %h want 00003004", bus.pc4); end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL basic_refetch got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.imem_addr !== 32'h0000_3004) begin miscompares++; $display("FAIL basic_next_addr got %h want 00003004", bus.imem_addr); end
  endtask

  task automatic test_hold_stall();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h8C09_0004;
    step();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b01) begin miscompares++; $display("FAIL stall_req_valid[%0d] got %b want 01", i, {bus.imem_req, bus.inst_valid}); end
      vectors++; if (bus.inst !== 32'h8C09_0004) begin miscompares++; $display("FAIL stall_inst[%0d] got %h want 8c090004", i, bus.inst); end
      vectors++; if (bus.inst_pc !== 32'h0000_3004) begin miscompares++; $display("FAIL stall_inst_pc[%0d] got %h want 00003004", i, bus.inst_pc); end
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    vectors++; if (bus.imem_addr !== 32'h0000_3008) begin miscompares++; $display("FAIL stall_next_addr got %h want 00003008", bus.imem_addr); end
  endtask

  task automatic test_redirect_grant();
    bus.imem_gnt    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3100;
    step();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid, bus.adel} !== 3'b000) begin miscompares++; $display("FAIL drop_req_valid_adel got %b want 000", {bus.imem_req, bus.inst_valid, bus.adel}); end
    vectors++; if (bus.imem_addr !== 32'h0000_3100) begin miscompares++; $display("FAIL drop_addr got %h want 00003100", bus.imem_addr); end
    step();
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL drop_wait_req got %0b want 0", bus.imem_req); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL drop_done got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.inst_pc !== 32'h0000_3004) begin miscompares++; $display("FAIL drop_inst_pc got %h want 00003004", bus.inst_pc); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.inst_pc !== 32'h0000_3100) begin miscompares++; $display("FAIL redir_inst_pc got %h want 00003100", bus.inst_pc); end
    vectors++; if (bus.inst !== 32'h1111_1111) begin miscompares++; $display("FAIL redir_inst got %h want 11111111", bus.inst); end
  endtask

  task automatic test_redirect_hold_misaligned();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3102;
    bus.inst_ready  = 1'b1;
    step();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    vectors++; if (bus.adel !== 1'b1) begin miscompares++; $display("FAIL adel_set got %0b want 1", bus.adel); end
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL hold_redir got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.imem_addr !== 32'h0000_3100) begin miscompares++; $display("FAIL hold_redir_addr got %h want 00003100", bus.imem_addr); end
    step();
    vectors++; if (bus.adel !== 1'b0) begin miscompares++; $display("FAIL adel_clear got %0b want 0", bus.adel); end
    vectors++; if (bus.imem_addr !== 32'h0000_3100) begin miscompares++; $display("FAIL fetch_hold_addr got %h want 00003100", bus.imem_addr); end
  endtask

  task automatic test_redirect_fetch_nogrant();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3200;
    step();
    bus.redirect = 1'b0;
    vectors++; if ({bus.imem_req, bus.adel} !== 2'b10) begin miscompares++; $display("FAIL nogrant_req_adel got %b want 10", {bus.imem_req, bus.adel}); end
    vectors++; if (bus.imem_addr !== 32'h0000_3200) begin miscompares++; $display("FAIL nogrant_addr got %h want 00003200", bus.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3300;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0001;
    step();
    bus.redirect    = 1'b0;
    bus.imem_rvalid = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL wait_rv_redir got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.inst !== 32'h1111_1111) begin miscompares++; $display("FAIL wait_rv_inst got %h want 11111111", bus.inst); end
    vectors++; if (bus.inst_pc !== 32'h0000_3100) begin miscompares++; $display("FAIL wait_rv_inst_pc got %h want 00003100", bus.inst_pc); end
    vectors++; if (bus.imem_addr !== 32'h0000_3300) begin miscompares++; $display("FAIL wait_rv_addr got %h want 00003300", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3400;
    step();
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL wait_norv_req got %0b want 0", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0000_3400) begin miscompares++; $display("FAIL wait_norv_addr got %h want 00003400", bus.imem_addr); end
    bus.redirect_pc = 32'h0000_3500;
    step();
    bus.redirect = 1'b0;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL drop_redir_req got %0b want 0", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0000_3500) begin miscompares++; $display("FAIL drop_redir_addr got %h want 00003500", bus.imem_addr); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0002;
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL drop_exit got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.inst !== 32'h1111_1111) begin miscompares++; $display("FAIL drop_exit_inst got %h want 11111111", bus.inst); end
  endtask

  task automatic test_wrap();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h03E0_0008;
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_inst_pc got %h want fffffffc", bus.inst_pc); end
    vectors++; if (bus.pc4 !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_pc4 got %h want 00000000", bus.pc4); end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    vectors++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0000}) begin miscompares++; $display("FAIL wrap_next got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.imem_req, bus.inst_valid, bus.adel} !== 3'b000) begin miscompares++; $display("FAIL arst_ctrl got %b want 000", {bus.imem_req, bus.inst_valid, bus.adel}); end
    vectors++; if (bus.imem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL arst_addr got %h want 00003000", bus.imem_addr); end
    vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL arst_inst got %h want 00000000", bus.inst); end
    vectors++; if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL arst_inst_pc got %h want 00000000", bus.inst_pc); end
    vectors++; if (bus.pc4 !== 32'h4) begin miscompares++; $display("FAIL arst_pc4 got %h want 00000004", bus.pc4); end
    step();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0003;
    step();
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL stray_state got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL stray_inst got %h want 00000000", bus.inst); end
    vectors++; if (bus.imem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL stray_addr got %h want 00003000", bus.imem_addr); end
    step();
    bus.imem_rvalid = 1'b0;
    vectors++; if ({bus.imem_req, bus.inst_valid} !== 2'b10) begin miscompares++; $display("FAIL stray_fetch got %b want 10", {bus.imem_req, bus.inst_valid}); end
    vectors++; if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL stray_inst_pc got %h want 00000000", bus.inst_pc); end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.inst_ready  = 1'b0;

    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_grant();
    test_redirect_hold_misaligned();
    test_redirect_fetch_nogrant();
    test_redirect_wait();
    test_wrap();
    test_reset_in_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port redirect  input  1  pulse; replaces the sequential fetch address (branch, jump or jr target from the next-PC logic).
REQ-005 SHALL have port redirect_pc  input  32  target address, sampled when redirect=1.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-007 SHALL have port imem_addr  output  32  request address; always equals the internal fetch PC (fpc).
REQ-008 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  response data valid; exactly one response per grant, earliest one cycle after the grant.
REQ-010 SHALL have port imem_rdata  input  32  response instruction word.
REQ-011 SHALL have port inst_valid  output  1  instruction buffer holds a valid word.
REQ-012 SHALL have port inst_ready  input  1  decode accepts the buffered word.
REQ-013 SHALL have port inst  output  32  buffered instruction word.
REQ-014 SHALL have port inst_pc  output  32  address of the buffered word.
REQ-015 SHALL have port pc4  output  32  inst_pc + 4, mod 2^32, for link writes and the next-PC logic.
REQ-016 SHALL have port adel  output  1  one-cycle pulse flagging a misaligned redirect target.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, DROP and HOLD; imem_req=1 only in FETCH; inst_valid=1 only in HOLD.
REQ-018 IDLE: SHALL move to FETCH on the first clock edge after rst_n is deasserted.
REQ-019 FETCH: on imem_gnt=1, SHALL move to WAIT; otherwise SHALL stay in FETCH with imem_addr held stable.
REQ-020 WAIT: on imem_rvalid=1, SHALL load inst<=imem_rdata, inst_pc<=fpc and fpc<=fpc+4 (wrapping mod 2^32), then move to HOLD.
REQ-021 HOLD: on inst_ready=1, SHALL move to FETCH on the same edge; otherwise inst, inst_pc and inst_valid SHALL stay unchanged.
REQ-022 Minimum latency SHALL be: grant in cycle N, rvalid in N+1, inst_valid=1 in N+2; at most one memory request SHALL be outstanding.
REQ-023 redirect SHALL take priority over every other transition and SHALL load fpc <= {redirect_pc[31:2],2'b00}.
REQ-024 redirect in FETCH without grant SHALL stay in FETCH, with the new address driven the next cycle.
REQ-025 redirect in FETCH with grant in the same cycle SHALL move to DROP.
REQ-026 redirect in WAIT without rvalid SHALL move to DROP.
REQ-027 redirect in WAIT with rvalid in the same cycle SHALL discard the data, leave inst and inst_pc unchanged, and move to FETCH.
REQ-028 redirect in HOLD SHALL clear inst_valid on the next edge, even if inst_ready=1 in that cycle, and move to FETCH.
REQ-029 DROP SHALL discard the next imem_rvalid and move to FETCH; redirect in DROP SHALL update fpc and remain in DROP until that response arrives.
REQ-030 adel SHALL be 1 in the cycle after any redirect with redirect_pc[1:0] != 0, and 0 otherwise.
REQ-031 imem_rvalid in FETCH, HOLD or IDLE SHALL be ignored.

Reset
REQ-032 While rst_n=0: state=IDLE, fpc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, imem_req=0, adel=0, with pc4=32'h0000_0004.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding request, and a late rvalid after release SHALL be ignored per REQ-031.

Verification
REQ-034 Release reset, grant immediately, rvalid next cycle with 32'h2408_0001, inst_ready=1 -> first imem_addr=32'h0000_3000; inst=32'h2408_0001, inst_pc=32'h3000 and pc4=32'h3004; next imem_addr=32'h3004.
REQ-035 Hold inst_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst/inst_pc stable, imem_req=0 throughout.
REQ-036 Redirect to 32'h0000_3100 in the cycle of grant for 32'h3008 -> the response for 32'h3008 is dropped, the next request goes to 32'h3100, and inst_pc never equals 32'h3008.
REQ-037 Redirect to 32'h0000_3102 in HOLD -> adel=1 for exactly one cycle, inst_valid=0 next cycle, and the next request goes to 32'h3100.
REQ-038 fpc=32'hFFFF_FFFC, fetch completes -> next imem_addr=32'h0000_0000 and pc4=32'h0000_0000.
REQ-039 Assert rst_n=0 in WAIT, then release -> all outputs take their reset values asynchronously, and a stray rvalid in the first cycle is ignored.
